// File: rtl/avalon_counter_pio_pkg.sv
// rtl/avalon_counter_pio_pkg.sv - register map and bit positions for the counter PIO
package avalon_counter_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIOD  = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_DIR     = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_ONESHOT = 3;

  localparam int STAT_WRAPPED = 0;
  localparam int STAT_RUNNING = 1;

endpackage

// File: rtl/avalon_counter_pio_if.sv
// rtl/avalon_counter_pio_if.sv - Avalon-MM slave register bus for the counter PIO
interface avalon_counter_pio_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/counter_pio_prescaler.sv
// rtl/counter_pio_prescaler.sv - reloading down-counter issuing one tick every period+1 clocks
module counter_pio_prescaler #(
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run,
  input  logic                      load,
  input  logic [PRESCALE_WIDTH-1:0] period,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= period;
    end else if (run) begin
      count <= (count == '0) ? period : count - PRESCALE_WIDTH'(1);
    end
  end

  assign tick = run & ~load & (count == '0);

endmodule

// File: rtl/avalon_counter_pio.sv
// rtl/avalon_counter_pio.sv - output PIO with prescaled up/down counter; AVALON_COUNTER_PIO_OUTREG_EN adds an out_port register
module avalon_counter_pio
  import avalon_counter_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    PRESCALE_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_counter_pio_if.slave   bus,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0]     data, data_next;
  logic [3:0]                ctrl, ctrl_next;
  logic [PRESCALE_WIDTH-1:0] period, period_next;
  logic                      wrapped, wrapped_next;
  logic                      wr, data_wr, load, tick, wrap_evt;
  logic [DATA_WIDTH-1:0]     wd;
  logic                      unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wd           = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;
  assign data_wr      = wr && (bus.address == ADDR_DATA || bus.address == ADDR_OUTSET ||
                               bus.address == ADDR_OUTCLR);
  assign load         = wr && (bus.address == ADDR_CONTROL) &&
                        bus.writedata[CTRL_RUN] && !ctrl[CTRL_RUN];

  counter_pio_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (ctrl[CTRL_RUN]),
    .load    (load),
    .period  (period),
    .tick    (tick)
  );

  always_comb begin
    data_next    = data;
    ctrl_next    = ctrl;
    period_next  = period;
    wrapped_next = wrapped;
    wrap_evt     = 1'b0;
    // A bus write to the data register discards a coincident tick.
    if (tick && !data_wr) begin
      if (!ctrl[CTRL_DIR]) begin
        if (data == '1) begin
          wrap_evt = 1'b1;
          if (ctrl[CTRL_ONESHOT]) ctrl_next[CTRL_RUN] = 1'b0;
          else                    data_next = '0;
        end else begin
          data_next = data + DATA_WIDTH'(1);
        end
      end else begin
        if (data == '0) begin
          wrap_evt = 1'b1;
          if (ctrl[CTRL_ONESHOT]) ctrl_next[CTRL_RUN] = 1'b0;
          else                    data_next = '1;
        end else begin
          data_next = data - DATA_WIDTH'(1);
        end
      end
    end
    if (wr) begin
      case (bus.address)
        ADDR_DATA:    data_next   = wd;
        ADDR_CONTROL: ctrl_next   = bus.writedata[3:0];
        ADDR_PERIOD:  period_next = bus.writedata[PRESCALE_WIDTH-1:0];
        ADDR_STATUS:  if (bus.writedata[STAT_WRAPPED]) wrapped_next = 1'b0;
        ADDR_OUTSET:  data_next   = data | wd;
        ADDR_OUTCLR:  data_next   = data & ~wd;
        default:      ;
      endcase
    end
    // A wrap outranks a simultaneous write-1-to-clear.
    if (wrap_evt) wrapped_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data    <= RESET_VALUE;
      ctrl    <= '0;
      period  <= '0;
      wrapped <= 1'b0;
    end else begin
      data    <= data_next;
      ctrl    <= ctrl_next;
      period  <= period_next;
      wrapped <= wrapped_next;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata = 32'(data);
      ADDR_CONTROL: bus.readdata = 32'(ctrl);
      ADDR_PERIOD:  bus.readdata = 32'(period);
      ADDR_STATUS: begin
        bus.readdata[STAT_WRAPPED] = wrapped;
        bus.readdata[STAT_RUNNING] = ctrl[CTRL_RUN];
      end
      default:      bus.readdata = '0;
    endcase
  end

  assign irq = wrapped & ctrl[CTRL_IRQ_EN];

`ifdef AVALON_COUNTER_PIO_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_q <= RESET_VALUE;
    else          out_q <= data;
  end

  assign out_port = out_q;
`else
  assign out_port = data;
`endif

endmodule

// File: tb/tb_avalon_counter_pio.sv
// tb/tb_avalon_counter_pio.sv - directed self-checking bench for avalon_counter_pio
module tb_avalon_counter_pio;

`ifdef AVALON_COUNTER_PIO_OUTREG_EN
  localparam int OUT_EXTRA = 1;
`else
  localparam int OUT_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] out_port;
  logic        irq;
  logic [31:0] v;
  int          total = 0;
  int          passed = 0;

  avalon_counter_pio_if bus();

  avalon_counter_pio #(
    .DATA_WIDTH     (16),
    .PRESCALE_WIDTH (24),
    .RESET_VALUE    (16'h00A5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

    #12;
    chk("reset_out_port", 32'(out_port), 32'h00A5);
    chk("reset_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd0, v); chk("reset_data", v, 32'h00A5);
    rd(3'd1, v); chk("reset_control", v, 32'h0);
    rd(3'd2, v); chk("reset_period", v, 32'h0);
    rd(3'd3, v); chk("reset_status", v, 32'h0);

    @(negedge clk);
    wr(3'd0, 32'hABCD_1234); idle(OUT_EXTRA);
    chk("write_data", 32'(out_port), 32'h1234);
    wr(3'd4, 32'h0000_000F); idle(OUT_EXTRA);
    chk("outset", 32'(out_port), 32'h123F);
    wr(3'd5, 32'h0000_1200); idle(OUT_EXTRA);
    chk("outclr", 32'(out_port), 32'h003F);
    rd(3'd4, v); chk("outset_reads0", v, 32'h0);
    rd(3'd5, v); chk("outclr_reads0", v, 32'h0);
    @(negedge clk);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd0, v); chk("addr6_ignored", v, 32'h003F);
    rd(3'd6, v); chk("addr6_reads0", v, 32'h0);
    rd(3'd7, v); chk("addr7_reads0", v, 32'h0);

    // Up count, PERIOD=3: first tick four edges after the CONTROL write.
    @(negedge clk);
    wr(3'd0, 32'h0);
    wr(3'd2, 32'd3);
    wr(3'd1, 32'h1);
    idle(3); rd(3'd0, v); chk("cnt_before_first", v, 32'h0);
    idle(1); rd(3'd0, v); chk("cnt_1", v, 32'h1);
    idle(4); rd(3'd0, v); chk("cnt_2", v, 32'h2);
    idle(3); rd(3'd0, v); chk("cnt_hold_2", v, 32'h2);
    idle(1); rd(3'd0, v); chk("cnt_3", v, 32'h3);
    wr(3'd1, 32'h0);
    idle(6); rd(3'd0, v); chk("stopped_hold", v, 32'h3);

    // Up wrap with PERIOD=0, irq and W1C while counting.
    @(negedge clk);
    wr(3'd0, 32'hFFFE);
    wr(3'd2, 32'd0);
    wr(3'd1, 32'h5);
    rd(3'd0, v); chk("wrap_start", v, 32'hFFFE);
    idle(1); rd(3'd0, v); chk("wrap_ffff", v, 32'hFFFF);
    idle(1); rd(3'd0, v); chk("wrap_0000", v, 32'h0000);
    rd(3'd3, v); chk("wrap_status", v, 32'h3);
    chk("wrap_irq", 32'(irq), 32'h1);
    wr(3'd3, 32'h1);
    chk("w1c_irq", 32'(irq), 32'h0);
    rd(3'd0, v); chk("w1c_still_counting", v, 32'h0001);
    wr(3'd1, 32'h0);
    rd(3'd0, v); chk("stop_with_last_tick", v, 32'h0002);

    // Down oneshot from 1 terminates at 0.
    @(negedge clk);
    wr(3'd0, 32'h1);
    wr(3'd1, 32'hB);
    idle(1); rd(3'd0, v); chk("oneshot_0", v, 32'h0);
    rd(3'd3, v); chk("oneshot_status_run", v, 32'h2);
    idle(1); rd(3'd1, v); chk("oneshot_control", v, 32'hA);
    rd(3'd3, v); chk("oneshot_status_done", v, 32'h1);
    idle(3); rd(3'd0, v); chk("oneshot_hold", v, 32'h0);
    chk("oneshot_irq_masked", 32'(irq), 32'h0);
    wr(3'd3, 32'h1);

    // DATA write coincident with a tick wins; prescaler still reloads.
    @(negedge clk);
    wr(3'd0, 32'h0);
    wr(3'd2, 32'd3);
    wr(3'd1, 32'h1);
    idle(3);
    wr(3'd0, 32'h5555);
    rd(3'd0, v); chk("coincident_write", v, 32'h5555);
    idle(3); rd(3'd0, v); chk("coincident_hold", v, 32'h5555);
    idle(1); rd(3'd0, v); chk("coincident_next_tick", v, 32'h5556);

    // Asynchronous reset between clock edges.
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_out", 32'(out_port), 32'h00A5);
    rd(3'd1, v); chk("async_reset_control", v, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    rd(3'd0, v); chk("after_reset_idle", v, 32'h00A5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
